// File: rtl/asymmetric_distributed_ram_pkg.sv
// Width helpers shared across the codebase: ceiling log2, power-of-two test
// and integer max, all usable in constant expressions.
package asymmetric_distributed_ram_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/asymmetric_distributed_ram.sv
// Distributed RAM with a wide synchronous write port and a narrow asynchronous
// read port; read sub-words are selected little-endian within each wide word.
module asymmetric_distributed_ram
  import asymmetric_distributed_ram_pkg::*;
#(
  parameter int WIDTH_IN  = 64,
  parameter int WIDTH_OUT = 8,
  parameter int DEPTH_IN  = 32,
  localparam int RATIO      = WIDTH_IN / WIDTH_OUT,
  localparam int LOG2_RATIO = clog2(RATIO),
  localparam int DEPTH_OUT  = DEPTH_IN * RATIO,
  localparam int AW_IN      = max_int(clog2(DEPTH_IN), 1),
  localparam int AW_OUT     = AW_IN + LOG2_RATIO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW_IN-1:0]     waddr,
  input  logic [WIDTH_IN-1:0]  d,
  input  logic [AW_OUT-1:0]    raddr,
  output logic [WIDTH_OUT-1:0] q
);

  if ((WIDTH_IN % WIDTH_OUT) != 0 || !is_pow2(RATIO) ||
      DEPTH_IN < 2 || !is_pow2(DEPTH_IN) || DEPTH_OUT != DEPTH_IN * RATIO)
  begin : g_bad_params
    $error("asymmetric_distributed_ram: illegal WIDTH_IN/WIDTH_OUT/DEPTH_IN");
  end

  logic [WIDTH_IN-1:0] mem [DEPTH_IN];

  // Reset clears the whole array; writes are held off for as long as rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_IN; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= d;
    end
  end

  logic [AW_IN-1:0]                  word_sel;
  logic [RATIO-1:0][WIDTH_OUT-1:0]   slices;

  assign word_sel = raddr[AW_OUT-1:LOG2_RATIO];
  assign slices   = mem[word_sel];

  if (LOG2_RATIO == 0) begin : g_no_slice
    assign q = slices[0];
  end else begin : g_slice
    logic [LOG2_RATIO-1:0] slice_sel;
    assign slice_sel = raddr[LOG2_RATIO-1:0];
    assign q         = slices[slice_sel];
  end

endmodule

// File: tb/tb_asymmetric_distributed_ram.sv
// Directed bench for the 64->8 asymmetric RAM: the driver pushes hand-computed
// read expectations into a queue and a monitor pops and compares them.
module tb_asymmetric_distributed_ram;

  localparam int WIDTH_IN  = 64;
  localparam int WIDTH_OUT = 8;
  localparam int DEPTH_IN  = 32;
  localparam int AW_IN     = 5;
  localparam int AW_OUT    = 8;

  logic                 clk;
  logic                 rst;
  logic                 we;
  logic [AW_IN-1:0]     waddr;
  logic [WIDTH_IN-1:0]  d;
  logic [AW_OUT-1:0]    raddr;
  logic [WIDTH_OUT-1:0] q;

  asymmetric_distributed_ram #(
    .WIDTH_IN (WIDTH_IN),
    .WIDTH_OUT(WIDTH_OUT),
    .DEPTH_IN (DEPTH_IN)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(waddr),
    .d    (d),
    .raddr(raddr),
    .q    (q)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [WIDTH_OUT-1:0] exp_q[$];
  logic [AW_OUT-1:0]    addr_q[$];
  string                name_q[$];
  int                   checks = 0;
  int                   errors = 0;
  event                 sample_ev;

  initial begin : monitor
    logic [WIDTH_OUT-1:0] exp_v;
    logic [AW_OUT-1:0]    addr_v;
    string                name_v;
    forever begin
      @(sample_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: sample with empty expected queue (q=%h)", "scoreboard", q);
      end else begin
        exp_v  = exp_q.pop_front();
        addr_v = addr_q.pop_front();
        name_v = name_q.pop_front();
        if (q !== exp_v) begin
          errors++;
          $display("FAIL %s: raddr=%0d q=%h expected %h at %0t",
                   name_v, addr_v, q, exp_v, $time);
        end
      end
    end
  end

  // driver tasks
  task automatic check_now(input logic [AW_OUT-1:0] a, input logic [WIDTH_OUT-1:0] e,
                           input string name);
    raddr = a;
    #1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    name_q.push_back(name);
    ->sample_ev;
    #1;
  endtask

  task automatic check_at(input logic [AW_OUT-1:0] a, input logic [WIDTH_OUT-1:0] e,
                          input string name);
    @(negedge clk);
    check_now(a, e, name);
  endtask

  task automatic write_word(input logic [AW_IN-1:0] a, input logic [WIDTH_IN-1:0] v);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    d     = v;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  initial begin : stimulus
    logic [7:0] b;
    rst   = 1'b0;
    we    = 1'b0;
    waddr = '0;
    d     = '0;
    raddr = '0;

    // reset state
    #2;
    check_now(8'd0,   8'h00, "reset_q_0");
    check_now(8'd255, 8'h00, "reset_q_255");
    @(negedge clk);
    rst = 1'b1;

    // basic write and little-endian sweep
    write_word(5'd0, 64'h8877665544332211);
    for (int i = 0; i < 8; i++) begin
      b = 8'((i + 1) * 8'h11);
      check_at(8'(i), b, "basic_sweep");
    end

    // top word
    write_word(5'd31, 64'hF0E0D0C0B0A09080);
    check_at(8'd248, 8'h80, "top_low");
    check_at(8'd250, 8'hA0, "top_mid");
    check_at(8'd255, 8'hF0, "top_high");
    check_at(8'd0,   8'h11, "word0_kept");
    check_at(8'd7,   8'h88, "word0_kept_hi");

    // write enable gating
    write_word(5'd5, 64'h0706050403020100);
    @(negedge clk);
    we    = 1'b0;
    waddr = 5'd5;
    d     = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      check_at(8'(40 + i), 8'(i), "we_gating");
    end

    // read during write
    write_word(5'd2, 64'h1111111111111111);
    @(negedge clk);
    raddr = 8'd16;
    we    = 1'b1;
    waddr = 5'd2;
    d     = 64'h22222222222222AB;
    check_now(8'd16, 8'h11, "rdw_before_edge");
    @(posedge clk);
    #1;
    check_now(8'd16, 8'hAB, "rdw_after_edge");
    we = 1'b0;
    check_at(8'd17, 8'h22, "rdw_neighbour");

    // fill all words, then reset mid-cycle
    for (int w = 0; w < DEPTH_IN; w++) begin
      write_word(5'(w), {8{8'(w + 1)}});
    end
    check_at(8'd24,  8'h04, "fill_w3");
    check_at(8'd255, 8'h20, "fill_w31");
    @(posedge clk);
    #2;
    rst = 1'b0;
    check_now(8'd24,  8'h00, "reset_clear_now");
    check_now(8'd255, 8'h00, "reset_clear_now");
    for (int i = 0; i < 256; i += 9) begin
      check_at(8'(i), 8'h00, "reset_clear_sweep");
    end

    // writes blocked while in reset
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd7;
    d     = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_now(8'd56, 8'h00, "write_in_reset");
    @(negedge clk);
    we  = 1'b0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      check_at(8'(56 + i), 8'h00, "after_release");
    end

    // normal writes resume after release
    write_word(5'd7, 64'h0123456789ABCDEF);
    check_at(8'd56, 8'hEF, "resume_low");
    check_at(8'd63, 8'h01, "resume_high");

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected entries left, required 0", "drain", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/asymmetric_distributed_ram.md
ASYMMETRIC_DISTRIBUTED_RAM -- requirements
Module: asymmetric_distributed_ram

Interface
- REQ-001 SHALL have parameter WIDTH_IN, default 64: write-port word width in bits.
- REQ-002 SHALL have parameter WIDTH_OUT, default 8: read-port word width in bits.
- REQ-003 SHALL have parameter DEPTH_IN, default 32: number of WIDTH_IN-wide words.
- REQ-004 SHALL derive localparams:
  - RATIO = WIDTH_IN/WIDTH_OUT.
  - LOG2_RATIO = log2(RATIO).
  - DEPTH_OUT = DEPTH_IN*RATIO.
  - AW_IN = ceil(log2(DEPTH_IN)), minimum 1.
  - AW_OUT = AW_IN + LOG2_RATIO.
- REQ-005 clk  input  1  single clock; all writes occur on its rising edge.
- REQ-006 rst  input  1  reset, asynchronous, active-low.
- REQ-007 we  input  1  write enable.
- REQ-008 waddr  input  AW_IN  write word address.
- REQ-009 d  input  WIDTH_IN  write data.
- REQ-010 raddr  input  AW_OUT  read sub-word address.
- REQ-011 q  output  WIDTH_OUT  read data.
- REQ-012 Port order SHALL be clk, rst, we, waddr, d, raddr, q.

Function
- REQ-013 Storage SHALL be DEPTH_IN words of WIDTH_IN bits, viewed on the read side as DEPTH_OUT words of WIDTH_OUT bits.
- REQ-014 When rst is high and we is 1 at a rising clk, word waddr SHALL be replaced by d; all other words are unchanged.
- REQ-015 When we is 0, memory SHALL be unchanged.
- REQ-016 Read SHALL be asynchronous (combinational, zero-cycle latency).
- REQ-017 q SHALL equal word[raddr[AW_OUT-1:LOG2_RATIO]] bits [(s+1)*WIDTH_OUT-1 : s*WIDTH_OUT], where s = raddr[LOG2_RATIO-1:0].
  - Little-endian slice order: s=0 selects the least-significant slice.
- REQ-018 Read-during-write to the same location:
  - q SHALL show the old contents until the clock edge.
  - q SHALL show the new contents immediately after the edge; no bypass.
- REQ-019 Parameter legality; elaboration SHALL fail otherwise:
  - WIDTH_IN SHALL be an integer multiple of WIDTH_OUT.
  - RATIO SHALL be a power of two, RATIO ≥ 1.
  - DEPTH_IN SHALL be a power of two, DEPTH_IN ≥ 2.
- REQ-020 Because depths are powers of two, every waddr/raddr value SHALL be in range; there is no wrap handling and no error output.
- REQ-021 RATIO=1 SHALL degenerate to a plain dual-port distributed RAM with raddr width AW_IN.

Reset
- REQ-022 rst low SHALL asynchronously clear every memory word to 0; q therefore reads 0 combinationally.
- REQ-023 Writes SHALL be ignored while rst is low, including a we=1 at the edge on which rst is released.
- REQ-024 Reset deassertion SHALL be synchronized externally; the block adds no synchronizer.

Structure
- REQ-025 A shared package SHALL provide the ceiling-log2 function used for AW_IN and LOG2_RATIO, together with the codebase's other width helpers.
- REQ-026 The design SHALL be a single module with no sub-modules: a register array plus a combinational word-select and slice-select mux.
- REQ-027 The design SHALL be synthesizable as LUT/distributed RAM or flops; no vendor primitives.

Verification (defaults 64/8/32)
- REQ-028 Basic write/read: after reset, write 0x8877665544332211 to waddr 0, then sweep raddr 0..7 -> q = 0x11,0x22,...,0x88 in the same cycle as each raddr change.
- REQ-029 Top word: write 0xF0E0D0C0B0A09080 to waddr 31 -> raddr 248 gives 0x80 and raddr 255 gives 0xF0; word 0 is unchanged.
- REQ-030 Write enable gating: we=0 with d=0xFFFFFFFFFFFFFFFF at waddr 5 -> raddr 40..47 still read the prior values.
- REQ-031 Read-during-write:
  - Setup: raddr=16, then write 0x...AB (low byte 0xAB) to waddr 2 over prior value 0x...11.
  - Before the edge, q = 0x11.
  - After the edge, q = 0xAB.
- REQ-032 Reset clears memory: fill all words, assert rst low mid-cycle -> q = 0 immediately for every raddr.
- REQ-033 Write blocked in reset: we=1 while rst is low -> write ignored and memory stays 0 after release.
